// File: rtl/raw_demosaic_bilinear_4p_pkg.sv
// Shared types for the 4-pixel bilinear demosaic: CFA site classes and the
// phase-to-site mapping used by the top level.
package raw_demosaic_bilinear_4p_pkg;

    localparam int PIX_PER_BEAT = 4;

    typedef enum logic [1:0] {
        SITE_R  = 2'd0,
        SITE_GR = 2'd1,
        SITE_GB = 2'd2,
        SITE_B  = 2'd3
    } site_e;

    // Pattern code bit0 shifts the CFA by one column, bit1 by one row.
    function automatic site_e site_of(input logic [1:0] pattern, input logic row_odd, input logic col_odd);
        return site_e'(pattern ^ {row_odd, col_odd});
    endfunction

endpackage

// File: rtl/raw_demosaic_bilinear_4p_if.sv
// Window-in / RGB-out stream bundle between the RAW window buffer, the
// demosaic and the colour path.
interface raw_demosaic_bilinear_4p_if;
    logic [95:0] I_win_last;
    logic [95:0] I_win_cur;
    logic [95:0] I_win_next;
    logic        I_bayer_ypos;
    logic        I_tvalid;
    logic        I_tlast;
    logic        I_tuser;
    logic        I_tready;
    logic        O_tready_up;
    logic [95:0] O_rgb;
    logic        O_tvalid;
    logic        O_tlast;
    logic        O_tuser;
    logic        O_fmt_err;

    modport slave (
        input  I_win_last, I_win_cur, I_win_next, I_bayer_ypos,
        input  I_tvalid, I_tlast, I_tuser, I_tready,
        output O_tready_up, O_rgb, O_tvalid, O_tlast, O_tuser, O_fmt_err
    );

    modport master (
        output I_win_last, I_win_cur, I_win_next, I_bayer_ypos,
        output I_tvalid, I_tlast, I_tuser, I_tready,
        input  O_tready_up, O_rgb, O_tvalid, O_tlast, O_tuser, O_fmt_err
    );
endinterface

// File: rtl/raw_demosaic_bilinear_4p_px_kernel.sv
// One-pixel bilinear kernel: stage 1 registers neighbour sums, stage 2 the
// rounded and site-selected RGB24 (zero when the beat was not valid).
module raw_demosaic_bilinear_4p_px_kernel
    import raw_demosaic_bilinear_4p_pkg::*;
(
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_valid,
    input  site_e       I_site,
    input  logic [7:0]  I_nw,
    input  logic [7:0]  I_n,
    input  logic [7:0]  I_ne,
    input  logic [7:0]  I_w,
    input  logic [7:0]  I_c,
    input  logic [7:0]  I_e,
    input  logic [7:0]  I_sw,
    input  logic [7:0]  I_s,
    input  logic [7:0]  I_se,
    output logic [23:0] O_rgb
);
    logic [9:0]  orth_sum_s, diag_sum_s, orth_sum_r, diag_sum_r;
    logic [8:0]  we_sum_s, ns_sum_s, we_sum_r, ns_sum_r;
    logic [7:0]  c_r, orth_avg_s, diag_avg_s, we_avg_s, ns_avg_s;
    site_e       site_r;
    logic        valid_r;
    logic [23:0] rgb_s, rgb_r;

    // Neighbour sums, widened so the worst case never wraps.
    always_comb begin
        orth_sum_s = 10'(I_n) + 10'(I_s) + 10'(I_w) + 10'(I_e);
        diag_sum_s = 10'(I_nw) + 10'(I_ne) + 10'(I_sw) + 10'(I_se);
        we_sum_s   = 9'(I_w) + 9'(I_e);
        ns_sum_s   = 9'(I_n) + 9'(I_s);
    end

    // Stage 1: sums, centre byte and site class.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            orth_sum_r <= 10'd0;
            diag_sum_r <= 10'd0;
            we_sum_r   <= 9'd0;
            ns_sum_r   <= 9'd0;
            c_r        <= 8'd0;
            site_r     <= SITE_R;
            valid_r    <= 1'b0;
        end else begin
            orth_sum_r <= orth_sum_s;
            diag_sum_r <= diag_sum_s;
            we_sum_r   <= we_sum_s;
            ns_sum_r   <= ns_sum_s;
            c_r        <= I_c;
            site_r     <= I_site;
            valid_r    <= I_valid;
        end
    end

    // Round-half-up averages and per-site channel selection.
    always_comb begin
        orth_avg_s = 8'((orth_sum_r + 10'd2) >> 2);
        diag_avg_s = 8'((diag_sum_r + 10'd2) >> 2);
        we_avg_s   = 8'((we_sum_r + 9'd1) >> 1);
        ns_avg_s   = 8'((ns_sum_r + 9'd1) >> 1);
        case (site_r)
            SITE_R:  rgb_s = {c_r, orth_avg_s, diag_avg_s};
            SITE_B:  rgb_s = {diag_avg_s, orth_avg_s, c_r};
            SITE_GR: rgb_s = {we_avg_s, c_r, ns_avg_s};
            SITE_GB: rgb_s = {ns_avg_s, c_r, we_avg_s};
            default: rgb_s = 24'd0;
        endcase
    end

    // Stage 2: registered pixel, forced to zero on idle beats.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            rgb_r <= 24'd0;
        end else if (valid_r) begin
            rgb_r <= rgb_s;
        end else begin
            rgb_r <= 24'd0;
        end
    end

    assign O_rgb = rgb_r;

endmodule

// File: rtl/raw_demosaic_bilinear_4p.sv
// Bilinear Bayer-to-RGB demosaic, 4 pixels per beat, fixed 2-cycle latency,
// with a sticky line-length / frame-truncation checker.
module raw_demosaic_bilinear_4p
    import raw_demosaic_bilinear_4p_pkg::*;
#(
    parameter int IMG_WIDTH     = 1920,
    parameter int IMG_HEIGHT    = 1080,
    parameter int BAYER_PATTERN = 0
) (
    input  logic I_clk,
    input  logic I_rst_n,
    raw_demosaic_bilinear_4p_if.slave bus
);
    localparam int            BEATS     = IMG_WIDTH / PIX_PER_BEAT;
    localparam int            HW        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int            VW        = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [HW-1:0] H_LAST    = HW'(BEATS - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(IMG_HEIGHT - 1);
    localparam logic [1:0]    CFA_PHASE = 2'(BAYER_PATTERN);

    logic          beat_ok_s, frame_active_r;
    logic [95:0]   rgb_s;
    logic          valid1_r, last1_r, user1_r, valid2_r, last2_r, user2_r;
    logic [HW-1:0] h_r, h_cur_s, h_next_s;
    logic [VW-1:0] v_r, v_cur_s, v_next_s;
    logic          err_r, err_next_s;
    logic          unused_s;

    // After reset nothing is accepted until a start-of-frame beat arrives.
    assign beat_ok_s = bus.I_tvalid & (bus.I_tuser | frame_active_r);
    assign unused_s  = ^{bus.I_win_last[95:72], bus.I_win_last[23:0],
                         bus.I_win_cur[95:72],  bus.I_win_cur[23:0],
                         bus.I_win_next[95:72], bus.I_win_next[23:0]};

    // Left neighbour of pixel k sits one byte above its centre, right one byte below.
    for (genvar k = 0; k < PIX_PER_BEAT; k++) begin : g_px
        raw_demosaic_bilinear_4p_px_kernel u_kernel (
            .I_clk   (I_clk),
            .I_rst_n (I_rst_n),
            .I_valid (beat_ok_s),
            .I_site  (site_of(CFA_PHASE, ~bus.I_bayer_ypos, 1'(k % 2))),
            .I_nw    (bus.I_win_last[71-8*k -: 8]),
            .I_n     (bus.I_win_last[63-8*k -: 8]),
            .I_ne    (bus.I_win_last[55-8*k -: 8]),
            .I_w     (bus.I_win_cur[71-8*k -: 8]),
            .I_c     (bus.I_win_cur[63-8*k -: 8]),
            .I_e     (bus.I_win_cur[55-8*k -: 8]),
            .I_sw    (bus.I_win_next[71-8*k -: 8]),
            .I_s     (bus.I_win_next[63-8*k -: 8]),
            .I_se    (bus.I_win_next[55-8*k -: 8]),
            .O_rgb   (rgb_s[95-24*k -: 24])
        );
    end

    // Sideband delay matching the kernel pipeline, plus frame-start gate.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            frame_active_r <= 1'b0;
            valid1_r <= 1'b0;
            last1_r  <= 1'b0;
            user1_r  <= 1'b0;
            valid2_r <= 1'b0;
            last2_r  <= 1'b0;
            user2_r  <= 1'b0;
        end else begin
            frame_active_r <= frame_active_r | (bus.I_tvalid & bus.I_tuser);
            valid1_r <= beat_ok_s;
            last1_r  <= beat_ok_s & bus.I_tlast;
            user1_r  <= beat_ok_s & bus.I_tuser;
            valid2_r <= valid1_r;
            last2_r  <= last1_r;
            user2_r  <= user1_r;
        end
    end

    // Format checker: tuser resets position first, then the tlast/length rules apply.
    always_comb begin
        h_cur_s    = bus.I_tuser ? {HW{1'b0}} : h_r;
        v_cur_s    = bus.I_tuser ? {VW{1'b0}} : v_r;
        h_next_s   = h_r;
        v_next_s   = v_r;
        err_next_s = err_r;
        if (beat_ok_s) begin
            if (bus.I_tuser) begin
                err_next_s = (v_r != {VW{1'b0}}) && (h_r != {HW{1'b0}});
            end else begin
                err_next_s = err_r;
            end
            if (bus.I_tlast) begin
                err_next_s = err_next_s | (h_cur_s != H_LAST);
                h_next_s   = {HW{1'b0}};
                v_next_s   = (v_cur_s == V_LAST) ? {VW{1'b0}} : v_cur_s + VW'(1);
            end else if (h_cur_s == H_LAST) begin
                err_next_s = 1'b1;
                h_next_s   = {HW{1'b0}};
                v_next_s   = v_cur_s;
            end else begin
                h_next_s   = h_cur_s + HW'(1);
                v_next_s   = v_cur_s;
            end
        end else begin
            err_next_s = err_r;
        end
    end

    // Checker state.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            h_r   <= {HW{1'b0}};
            v_r   <= {VW{1'b0}};
            err_r <= 1'b0;
        end else begin
            h_r   <= h_next_s;
            v_r   <= v_next_s;
            err_r <= err_next_s;
        end
    end

    assign bus.O_tready_up = bus.I_tready;
    assign bus.O_rgb       = rgb_s;
    assign bus.O_tvalid    = valid2_r;
    assign bus.O_tlast     = last2_r;
    assign bus.O_tuser     = user2_r;
    assign bus.O_fmt_err   = err_r;

endmodule

// File: tb/tb_raw_demosaic_bilinear_4p.sv
// Directed bench for raw_demosaic_bilinear_4p: reset, flat field, site maths,
// pattern sweep, format checker and asynchronous reset.
module tb_raw_demosaic_bilinear_4p;
    logic I_clk   = 1'b0;
    logic I_rst_n = 1'b0;
    int   n_vec   = 0;
    int   n_err   = 0;

    always #5 I_clk = ~I_clk;

    raw_demosaic_bilinear_4p_if ifm ();
    logic [3:0][95:0] sweep_rgb;

    raw_demosaic_bilinear_4p u_dut (.I_clk(I_clk), .I_rst_n(I_rst_n), .bus(ifm));
    assign sweep_rgb[0] = ifm.O_rgb;

    for (genvar p = 1; p < 4; p++) begin : g_pat
        raw_demosaic_bilinear_4p_if ifp ();
        assign ifp.I_win_last   = ifm.I_win_last;
        assign ifp.I_win_cur    = ifm.I_win_cur;
        assign ifp.I_win_next   = ifm.I_win_next;
        assign ifp.I_bayer_ypos = ifm.I_bayer_ypos;
        assign ifp.I_tvalid     = ifm.I_tvalid;
        assign ifp.I_tlast      = ifm.I_tlast;
        assign ifp.I_tuser      = ifm.I_tuser;
        assign ifp.I_tready     = ifm.I_tready;
        raw_demosaic_bilinear_4p #(.BAYER_PATTERN(p)) u_dut (.I_clk(I_clk), .I_rst_n(I_rst_n), .bus(ifp));
        assign sweep_rgb[p] = ifp.O_rgb;
    end

    localparam logic [95:0] FLAT = {12{8'h80}};

    function automatic logic [95:0] mk_row(input logic [7:0] l, p0, p1, p2, p3, r);
        return {24'h0, l, p0, p1, p2, p3, r, 24'h0};
    endfunction

    task automatic drive(input logic [95:0] wl, wc, wn, input logic ypos, last, user);
        @(negedge I_clk);
        ifm.I_win_last   = wl;
        ifm.I_win_cur    = wc;
        ifm.I_win_next   = wn;
        ifm.I_bayer_ypos = ypos;
        ifm.I_tlast      = last;
        ifm.I_tuser      = user;
        ifm.I_tvalid     = 1'b1;
    endtask

    task automatic idle();
        @(negedge I_clk);
        ifm.I_tvalid = 1'b0;
        ifm.I_tlast  = 1'b0;
        ifm.I_tuser  = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_vec++; if (ifm.O_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b want 0", ifm.O_tvalid); end
        n_vec++; if (ifm.O_rgb !== 96'd0) begin n_err++; $display("FAIL reset_rgb: got %h want 0", ifm.O_rgb); end
        n_vec++; if ({ifm.O_tlast, ifm.O_tuser, ifm.O_fmt_err} !== 3'b000) begin
            n_err++; $display("FAIL reset_side: got %b want 000", {ifm.O_tlast, ifm.O_tuser, ifm.O_fmt_err}); end
        @(negedge I_clk);
        I_rst_n = 1'b1;
    endtask

    task automatic test_tready();
        ifm.I_tready = 1'b0; #1;
        n_vec++; if (ifm.O_tready_up !== 1'b0) begin n_err++; $display("FAIL tready_lo: got %b want 0", ifm.O_tready_up); end
        ifm.I_tready = 1'b1; #1;
        n_vec++; if (ifm.O_tready_up !== 1'b1) begin n_err++; $display("FAIL tready_hi: got %b want 1", ifm.O_tready_up); end
    endtask

    task automatic test_flat_field();
        drive(FLAT, FLAT, FLAT, 1'b1, 1'b0, 1'b1);
        idle();
        n_vec++; if (ifm.O_tvalid !== 1'b0) begin n_err++; $display("FAIL flat_early: got %b want 0", ifm.O_tvalid); end
        idle();
        n_vec++; if ({ifm.O_tvalid, ifm.O_tuser} !== 2'b11) begin n_err++; $display("FAIL flat_valid_user: got %b want 11", {ifm.O_tvalid, ifm.O_tuser}); end
        n_vec++; if (ifm.O_rgb !== {4{24'h808080}}) begin n_err++; $display("FAIL flat_rgb: got %h want %h", ifm.O_rgb, {4{24'h808080}}); end
        n_vec++; if (sweep_rgb[3] !== {4{24'h808080}}) begin n_err++; $display("FAIL flat_rgb_bggr: got %h want %h", sweep_rgb[3], {4{24'h808080}}); end
        idle();
        n_vec++; if ({ifm.O_tvalid, ifm.O_tuser, ifm.O_rgb} !== 98'd0) begin
            n_err++; $display("FAIL flat_idle_zero: got %b %b %h want 0", ifm.O_tvalid, ifm.O_tuser, ifm.O_rgb); end
    endtask

    // Three consecutive beats: R-site window on an even row, same window on an odd row, G-site window.
    task automatic test_back_to_back();
        logic [95:0] a_l, a_c, a_n, b_l, b_c, b_n;
        a_l = mk_row(8'd50, 8'd100, 8'd51, 8'd0, 8'd0, 8'd0);
        a_c = mk_row(8'd101, 8'd200, 8'd101, 8'd0, 8'd0, 8'd0);
        a_n = mk_row(8'd52, 8'd100, 8'd53, 8'd0, 8'd0, 8'd0);
        b_l = mk_row(8'd0, 8'd0, 8'd20, 8'd0, 8'd0, 8'd0);
        b_c = mk_row(8'd0, 8'd10, 8'd77, 8'd11, 8'd0, 8'd0);
        b_n = mk_row(8'd0, 8'd0, 8'd23, 8'd0, 8'd0, 8'd0);
        drive(a_l, a_c, a_n, 1'b1, 1'b0, 1'b1);
        drive(a_l, a_c, a_n, 1'b0, 1'b0, 1'b0);
        drive(b_l, b_c, b_n, 1'b1, 1'b0, 1'b0);
        n_vec++; if (ifm.O_rgb[95:48] !== {8'd200, 8'd101, 8'd52, 8'd100, 8'd101, 8'd52}) begin
            n_err++; $display("FAIL rsite_even: got %h want %h", ifm.O_rgb[95:48], {8'd200, 8'd101, 8'd52, 8'd100, 8'd101, 8'd52}); end
        idle();
        n_vec++; if (ifm.O_rgb[95:48] !== {8'd100, 8'd200, 8'd101, 8'd50, 8'd76, 8'd101}) begin
            n_err++; $display("FAIL odd_row: got %h want %h", ifm.O_rgb[95:48], {8'd100, 8'd200, 8'd101, 8'd50, 8'd76, 8'd101}); end
        idle();
        n_vec++; if ({ifm.O_tvalid, ifm.O_rgb[95:48]} !== {1'b1, 8'd10, 8'd19, 8'd11, 8'd11, 8'd77, 8'd22}) begin
            n_err++; $display("FAIL gsite_rrow: got %b %h want 1 %h", ifm.O_tvalid, ifm.O_rgb[95:48], {8'd10, 8'd19, 8'd11, 8'd11, 8'd77, 8'd22}); end
        idle();
    endtask

    // Parity-coded window: cur row even/odd cols 0x10/0x20, outer rows 0x30/0x40.
    task automatic test_pattern_sweep();
        logic [95:0] exp_rgb [4];
        logic [95:0] o_row, c_row;
        exp_rgb[0] = 96'h102840_102040_102840_102040;
        exp_rgb[1] = 96'h201030_202830_201030_202830;
        exp_rgb[2] = 96'h301020_302820_301020_302820;
        exp_rgb[3] = 96'h402810_402010_402810_402010;
        o_row = mk_row(8'h40, 8'h30, 8'h40, 8'h30, 8'h40, 8'h30);
        c_row = mk_row(8'h20, 8'h10, 8'h20, 8'h10, 8'h20, 8'h10);
        drive(o_row, c_row, o_row, 1'b1, 1'b0, 1'b1);
        idle();
        idle();
        for (int p = 0; p < 4; p++) begin
            n_vec++; if (sweep_rgb[p] !== exp_rgb[p]) begin
                n_err++; $display("FAIL sweep_pattern%0d: got %h want %h", p, sweep_rgb[p], exp_rgb[p]); end
        end
    endtask

    task automatic test_fmt_err();
        for (int i = 0; i < 479; i++) begin
            drive(FLAT, FLAT, FLAT, 1'b1, (i == 478), (i == 0));
            if (i == 478) begin
                n_vec++; if (ifm.O_fmt_err !== 1'b0) begin n_err++; $display("FAIL fmt_before: got %b want 0", ifm.O_fmt_err); end
            end
        end
        idle();
        n_vec++; if (ifm.O_fmt_err !== 1'b1) begin n_err++; $display("FAIL fmt_short_line: got %b want 1", ifm.O_fmt_err); end
        repeat (3) idle();
        n_vec++; if (ifm.O_fmt_err !== 1'b1) begin n_err++; $display("FAIL fmt_sticky: got %b want 1", ifm.O_fmt_err); end
        drive(FLAT, FLAT, FLAT, 1'b1, 1'b0, 1'b1);
        idle();
        n_vec++; if (ifm.O_fmt_err !== 1'b0) begin n_err++; $display("FAIL fmt_clear: got %b want 0", ifm.O_fmt_err); end
    endtask

    task automatic test_good_line();
        for (int i = 0; i < 480; i++) drive(FLAT, FLAT, FLAT, 1'b1, (i == 479), (i == 0));
        idle();
        n_vec++; if (ifm.O_fmt_err !== 1'b0) begin n_err++; $display("FAIL good_line_err: got %b want 0", ifm.O_fmt_err); end
        idle();
        n_vec++; if ({ifm.O_tvalid, ifm.O_tlast} !== 2'b11) begin n_err++; $display("FAIL good_line_tlast: got %b want 11", {ifm.O_tvalid, ifm.O_tlast}); end
    endtask

    task automatic test_truncated();
        drive(FLAT, FLAT, FLAT, 1'b1, 1'b0, 1'b0);
        drive(FLAT, FLAT, FLAT, 1'b1, 1'b0, 1'b0);
        drive(FLAT, FLAT, FLAT, 1'b1, 1'b0, 1'b1);
        n_vec++; if (ifm.O_fmt_err !== 1'b0) begin n_err++; $display("FAIL trunc_before: got %b want 0", ifm.O_fmt_err); end
        idle();
        n_vec++; if (ifm.O_fmt_err !== 1'b1) begin n_err++; $display("FAIL trunc_frame: got %b want 1", ifm.O_fmt_err); end
    endtask

    task automatic test_async_reset();
        bit seen;
        drive(FLAT, FLAT, FLAT, 1'b1, 1'b0, 1'b1);
        drive(FLAT, FLAT, FLAT, 1'b1, 1'b0, 1'b0);
        drive(FLAT, FLAT, FLAT, 1'b1, 1'b0, 1'b0);
        n_vec++; if (ifm.O_tvalid !== 1'b1) begin n_err++; $display("FAIL arst_pre: got %b want 1", ifm.O_tvalid); end
        #2 I_rst_n = 1'b0;
        #1;
        n_vec++; if ({ifm.O_tvalid, ifm.O_tlast, ifm.O_tuser, ifm.O_fmt_err, ifm.O_rgb} !== 100'd0) begin
            n_err++; $display("FAIL arst_outputs: got %b%b%b%b %h want 0", ifm.O_tvalid, ifm.O_tlast, ifm.O_tuser, ifm.O_fmt_err, ifm.O_rgb); end
        @(negedge I_clk);
        I_rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(FLAT, FLAT, FLAT, 1'b1, 1'b0, 1'b0);
            seen = seen | ifm.O_tvalid;
        end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL arst_no_frame: got %b want 0", seen); end
        drive(FLAT, FLAT, FLAT, 1'b1, 1'b0, 1'b1);
        idle();
        idle();
        n_vec++; if ({ifm.O_tvalid, ifm.O_rgb} !== {1'b1, {4{24'h808080}}}) begin
            n_err++; $display("FAIL arst_resume: got %b %h want 1 %h", ifm.O_tvalid, ifm.O_rgb, {4{24'h808080}}); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ifm.I_win_last   = 96'd0;
        ifm.I_win_cur    = 96'd0;
        ifm.I_win_next   = 96'd0;
        ifm.I_bayer_ypos = 1'b0;
        ifm.I_tvalid     = 1'b0;
        ifm.I_tlast      = 1'b0;
        ifm.I_tuser      = 1'b0;
        ifm.I_tready     = 1'b1;
        test_reset();
        test_tready();
        test_flat_field();
        test_back_to_back();
        test_pattern_sweep();
        test_fmt_err();
        test_good_line();
        test_truncated();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
